// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision adder datapath
// (alignment, Kogge-Stone adder, normalise/round).
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int SIG_W   = MAN_W + 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } cls_e;

    // Working significand: carry headroom, hidden bit, fraction, empty G/R/S.
    function automatic logic [SIG_W-1:0] pack_sig(input logic hidden, input logic [MAN_W-1:0] frac);
        return {1'b0, hidden, frac, 3'b000};
    endfunction

endpackage

// File: rtl/fp_shift_sticky.sv
// Combinational right shifter that folds every bit shifted out below bit 0
// into bit 0 (sticky).
module fp_shift_sticky
    import fp_pkg::*;
#(
    parameter int W    = SIG_W,
    parameter int SH_W = EXP_W
) (
    input  logic [W-1:0]    sig_in,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    sig_out
);

    logic [W-1:0] mask_s;

    // Shift with sticky; any shift of W-1 or more leaves only the sticky bit.
    always_comb begin
        mask_s  = {W{1'b0}};
        sig_out = {W{1'b0}};
        if (shamt >= SH_W'(W - 1)) begin
            sig_out = {{(W-1){1'b0}}, |sig_in};
        end else begin
            mask_s  = ~({W{1'b1}} << shamt);
            sig_out = (sig_in >> shamt) | {{(W-1){1'b0}}, |(sig_in & mask_s)};
        end
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage operand alignment for the binary32 adder: unpack/classify/order,
// then shift the smaller significand with sticky. Optional subnormal support
// is enabled by defining FP_ALIGN_SUBNORMAL_EN (default: flush to zero).
module fp_align_stage
    import fp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIG_W-1:0]       a_sig,
    output logic [SIG_W-1:0]       b_sig,
    output logic [EXP_W-1:0]       exp_out,
    output logic                   sign_out,
    output logic                   eff_sub,
    output logic [1:0]             cls
);

    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(EXP_MAX);

    logic                   adv1_s, adv2_s;
    logic [EXP_W-1:0]       ea_raw_s, eb_raw_s, ea_s, eb_s;
    logic [MAN_W-1:0]       fa_raw_s, fb_raw_s, fa_s, fb_s;
    logic                   sa_s, sb_s, ha_s, hb_s;
    logic                   nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic                   swap_s, eff_sub_s, sign_big_s;
    logic [EXP_W-1:0]       exp_big_s, diff_s;
    logic [SIG_W-1:0]       big_sig_s, small_sig_s;
    cls_e                   cls_s;

    logic                   valid1_r;
    logic [SIG_W-1:0]       big_sig_r, small_sig_r;
    logic [EXP_W-1:0]       exp1_r, diff1_r;
    logic                   sign1_r, eff1_r;
    cls_e                   cls1_r;

    logic                   out_valid_r;
    cls_e                   cls_r;
    logic [SIG_W-1:0]       b_shift_s;

    assign adv2_s    = !out_valid_r || out_ready;
    assign adv1_s    = !valid1_r || adv2_s;
    assign in_ready  = adv1_s;
    assign out_valid = out_valid_r;
    assign cls       = cls_r;

    // Stage 1: unpack, classify, order by magnitude, exponent difference.
    always_comb begin
        sa_s     = op_a[EXP_W+MAN_W];
        sb_s     = op_b[EXP_W+MAN_W] ^ op_sub;
        ea_raw_s = op_a[MAN_W +: EXP_W];
        eb_raw_s = op_b[MAN_W +: EXP_W];
        fa_raw_s = op_a[MAN_W-1:0];
        fb_raw_s = op_b[MAN_W-1:0];
        eff_sub_s = sa_s ^ sb_s;

        nan_a_s = (ea_raw_s == EXP_ONES) && (fa_raw_s != {MAN_W{1'b0}});
        nan_b_s = (eb_raw_s == EXP_ONES) && (fb_raw_s != {MAN_W{1'b0}});
        inf_a_s = (ea_raw_s == EXP_ONES) && (fa_raw_s == {MAN_W{1'b0}});
        inf_b_s = (eb_raw_s == EXP_ONES) && (fb_raw_s == {MAN_W{1'b0}});
        ha_s    = (ea_raw_s != {EXP_W{1'b0}});
        hb_s    = (eb_raw_s != {EXP_W{1'b0}});
        fa_s    = fa_raw_s;
        fb_s    = fb_raw_s;
        ea_s    = ea_raw_s;
        eb_s    = eb_raw_s;
`ifdef FP_ALIGN_SUBNORMAL_EN
        // Subnormals keep their fraction and behave as exponent 1.
        if (!ha_s && (fa_raw_s != {MAN_W{1'b0}})) begin
            ea_s = EXP_W'(1);
        end else begin
            ea_s = ea_raw_s;
        end
        if (!hb_s && (fb_raw_s != {MAN_W{1'b0}})) begin
            eb_s = EXP_W'(1);
        end else begin
            eb_s = eb_raw_s;
        end
        zero_a_s = !ha_s && (fa_raw_s == {MAN_W{1'b0}});
        zero_b_s = !hb_s && (fb_raw_s == {MAN_W{1'b0}});
`else
        if (!ha_s) begin
            fa_s = {MAN_W{1'b0}};
        end else begin
            fa_s = fa_raw_s;
        end
        if (!hb_s) begin
            fb_s = {MAN_W{1'b0}};
        end else begin
            fb_s = fb_raw_s;
        end
        zero_a_s = !ha_s;
        zero_b_s = !hb_s;
`endif

        // Hidden bit is part of the key so a subnormal never outranks exponent 1.
        swap_s = {eb_s, hb_s, fb_s} > {ea_s, ha_s, fa_s};
        if (swap_s) begin
            exp_big_s   = eb_s;
            diff_s      = eb_s - ea_s;
            sign_big_s  = sb_s;
            big_sig_s   = pack_sig(hb_s, fb_s);
            small_sig_s = pack_sig(ha_s, fa_s);
        end else begin
            exp_big_s   = ea_s;
            diff_s      = ea_s - eb_s;
            sign_big_s  = sa_s;
            big_sig_s   = pack_sig(ha_s, fa_s);
            small_sig_s = pack_sig(hb_s, fb_s);
        end

        if (nan_a_s || nan_b_s || (inf_a_s && inf_b_s && eff_sub_s)) begin
            cls_s = CLS_NAN;
        end else if (inf_a_s || inf_b_s) begin
            cls_s = CLS_INF;
        end else if (zero_a_s && zero_b_s) begin
            cls_s = CLS_ZERO;
        end else begin
            cls_s = CLS_NORMAL;
        end

        if (cls_s != CLS_NORMAL) begin
            big_sig_s   = {SIG_W{1'b0}};
            small_sig_s = {SIG_W{1'b0}};
        end else begin
            big_sig_s   = big_sig_s;
            small_sig_s = small_sig_s;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_r    <= 1'b0;
            big_sig_r   <= {SIG_W{1'b0}};
            small_sig_r <= {SIG_W{1'b0}};
            exp1_r      <= {EXP_W{1'b0}};
            diff1_r     <= {EXP_W{1'b0}};
            sign1_r     <= 1'b0;
            eff1_r      <= 1'b0;
            cls1_r      <= CLS_NORMAL;
        end else if (adv1_s) begin
            valid1_r <= in_valid;
            if (in_valid) begin
                big_sig_r   <= big_sig_s;
                small_sig_r <= small_sig_s;
                exp1_r      <= exp_big_s;
                diff1_r     <= diff_s;
                sign1_r     <= sign_big_s;
                eff1_r      <= eff_sub_s;
                cls1_r      <= cls_s;
            end
        end
    end

    fp_shift_sticky #(.W(SIG_W), .SH_W(EXP_W)) u_shift (
        .sig_in  (small_sig_r),
        .shamt   (diff1_r),
        .sig_out (b_shift_s)
    );

    // Stage 2 register: held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            a_sig       <= {SIG_W{1'b0}};
            b_sig       <= {SIG_W{1'b0}};
            exp_out     <= {EXP_W{1'b0}};
            sign_out    <= 1'b0;
            eff_sub     <= 1'b0;
            cls_r       <= CLS_NORMAL;
        end else if (adv2_s) begin
            out_valid_r <= valid1_r;
            if (valid1_r) begin
                a_sig    <= big_sig_r;
                b_sig    <= b_shift_s;
                exp_out  <= exp1_r;
                sign_out <= sign1_r;
                eff_sub  <= eff1_r;
                cls_r    <= cls1_r;
            end
        end
    end

endmodule
